fifo_uart_drain: RTL and testbench

Read-side consumer for the async FIFO: runs in the read clock domain, pops words through the FIFO read port (rempty/rinc/rdata) and transmits each word as an asynchronous serial frame on a single line. It is the draining end of the FIFO, paired with the existing write-side producer logic, and it is the only agent that drives rinc.

---
 rtl/fifo_uart_drain_if.sv | 11 +
 rtl/fifo_uart_drain.sv | 147 ++++++++++++++
 tb/tb_fifo_uart_drain.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_uart_drain_if.sv
// rtl/fifo_uart_drain_if.sv - FIFO read-port bundle (rempty/rinc/rdata) between the async FIFO and its drain
interface fifo_uart_drain_if #(
    parameter int DSIZE = 8
) ();
    logic             rempty;
    logic             rinc;
    logic [DSIZE-1:0] rdata;

    modport master (input rempty, input rdata, output rinc);
    modport slave  (output rempty, output rdata, input rinc);
endinterface

// File: rtl/fifo_uart_drain.sv
// rtl/fifo_uart_drain.sv - pops FIFO words and sends each as a serial frame; FIFO_UART_PARITY_EN adds even parity
module fifo_uart_drain #(
    parameter int DSIZE        = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                clk,
    input  logic                r_rst,
    input  logic                en,
    fifo_uart_drain_if.master   rd,
    output logic                tx,
    output logic                busy,
    output logic [7:0]          sent_cnt
);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(DSIZE);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] BIT_LAST  = IW'(DSIZE - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
`ifdef FIFO_UART_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [BW-1:0]    baud_q, baud_d;
    logic [IW-1:0]    bit_q, bit_d;
    logic [DSIZE-1:0] shift_q, shift_d;
    logic [7:0]       sent_q, sent_d;
    logic             rinc_o, tx_o, busy_o, baud_last;
`ifdef FIFO_UART_PARITY_EN
    logic             parity_q, parity_d;
`endif

    always_ff @(posedge clk) begin
        if (r_rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            sent_q   <= '0;
`ifdef FIFO_UART_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            sent_q   <= sent_d;
`ifdef FIFO_UART_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        sent_d    = sent_q;
        rinc_o    = 1'b0;
        tx_o      = 1'b1;
        busy_o    = 1'b1;
        baud_last = (baud_q == BAUD_LAST);
`ifdef FIFO_UART_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                busy_o = 1'b0;
                // Gated by r_rst so no word is popped while the drain is held in reset.
                if (en && !rd.rempty && !r_rst) begin
                    rinc_o  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                shift_d = rd.rdata;
                baud_d  = '0;
                bit_d   = '0;
`ifdef FIFO_UART_PARITY_EN
                parity_d = ^rd.rdata;
`endif
                state_d = START;
            end
            START: begin
                tx_o   = 1'b0;
                baud_d = baud_q + BW'(1);
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                tx_o   = shift_q[0];
                baud_d = baud_q + BW'(1);
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + IW'(1);
                    if (bit_q == BIT_LAST) begin
                        bit_d = '0;
`ifdef FIFO_UART_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef FIFO_UART_PARITY_EN
            PARITY: begin
                tx_o   = parity_q;
                baud_d = baud_q + BW'(1);
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                baud_d = baud_q + BW'(1);
                if (baud_last) begin
                    baud_d  = '0;
                    sent_d  = sent_q + 8'd1;
                    state_d = IDLE;
                end
            end
            default: begin
                busy_o  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign rd.rinc  = rinc_o;
    assign tx       = tx_o;
    assign busy     = busy_o;
    assign sent_cnt = sent_q;
endmodule

// File: tb/tb_fifo_uart_drain.sv
// tb/tb_fifo_uart_drain.sv - randomized self-checking bench for fifo_uart_drain against a frame-level model
module tb_fifo_uart_drain;
    localparam int DSIZE = 8;
    localparam int CPB   = 4;
`ifdef FIFO_UART_PARITY_EN
    localparam int NB = DSIZE + 3;
    localparam int BUSY_LEN = 45;
`else
    localparam int NB = DSIZE + 2;
    localparam int BUSY_LEN = 41;
`endif
    localparam int FL = NB * CPB;

    logic       clk = 1'b0;
    logic       r_rst = 1'b1;
    logic       en = 1'b0;
    logic       tx, busy;
    logic [7:0] sent_cnt;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    logic [7:0] fifo_q[$];
    int         pop_cyc[$];
    logic [7:0] pop_word[$];
    int         log_base = 0;
    int         pop_empty_err = 0;

    fifo_uart_drain_if #(.DSIZE(DSIZE)) rd ();

    fifo_uart_drain #(.DSIZE(DSIZE), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .r_rst(r_rst), .en(en), .rd(rd),
        .tx(tx), .busy(busy), .sent_cnt(sent_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: a pop seen mid-cycle takes effect just after the following edge.
    initial begin
        bit pend;
        int pend_cyc;
        pend = 1'b0;
        pend_cyc = 0;
        rd.rempty = 1'b1;
        rd.rdata = '0;
        forever begin
            @(negedge clk);
            if (rd.rinc === 1'b1) begin
                pend = 1'b1;
                pend_cyc = cyc;
                if (fifo_q.size() == 0) pop_empty_err++;
            end
            @(posedge clk);
            #2;
            if (pend && fifo_q.size() > 0) begin
                rd.rdata = fifo_q.pop_front();
                pop_word.push_back(rd.rdata);
                pop_cyc.push_back(pend_cyc);
            end
            pend = 1'b0;
            rd.rempty = (fifo_q.size() == 0);
        end
    end

    function automatic logic exp_tx(input int c);
        int k, b;
        for (int i = pop_cyc.size() - 1; i >= log_base; i--) begin
            if (pop_cyc[i] + 2 <= c) begin
                k = c - pop_cyc[i] - 2;
                if (k >= FL) return 1'b1;
                b = k / CPB;
                if (b == 0) return 1'b0;
                if (b <= DSIZE) return pop_word[i][b-1];
`ifdef FIFO_UART_PARITY_EN
                if (b == DSIZE + 1) return ^pop_word[i];
`endif
                return 1'b1;
            end
        end
        return 1'b1;
    endfunction

    function automatic logic exp_busy(input int c);
        for (int i = pop_cyc.size() - 1; i >= log_base; i--)
            if (pop_cyc[i] + 1 <= c) return (c <= pop_cyc[i] + FL + 1);
        return 1'b0;
    endfunction

    function automatic logic [7:0] exp_sent(input int c);
        int n;
        n = 0;
        for (int i = log_base; i < pop_cyc.size(); i++)
            if (c >= pop_cyc[i] + FL + 2) n++;
        return 8'(n);
    endfunction

    function automatic logic exp_rinc(input int c);
        return !r_rst && en && !rd.rempty && !exp_busy(c);
    endfunction

    task automatic push(input logic [7:0] w);
        fifo_q.push_back(w);
    endtask

    task automatic advance(input int n, output int tx_e, output int busy_e, output int rinc_e, output int cnt_e);
        tx_e = 0; busy_e = 0; rinc_e = 0; cnt_e = 0;
        repeat (n) begin
            @(negedge clk);
            if (tx !== exp_tx(cyc)) tx_e++;
            if (busy !== exp_busy(cyc)) busy_e++;
            if (rd.rinc !== exp_rinc(cyc)) rinc_e++;
            if (sent_cnt !== exp_sent(cyc)) cnt_e++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        int te, be, re, ce;
        en = 1'b1;
        push(8'h3C);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks += 4;
            if (rd.rinc !== 1'b0) begin errors++; $display("FAIL reset_rinc got %b want 0", rd.rinc); end
            if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
            if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
            if (sent_cnt !== 8'd0) begin errors++; $display("FAIL reset_sent got %0d want 0", sent_cnt); end
            @(posedge clk);
            #1;
        end
        r_rst = 1'b0;
        log_base = pop_cyc.size();
        @(negedge clk);
        checks++;
        if (rd.rinc !== 1'b1) begin errors++; $display("FAIL reset_first_pop got %b want 1", rd.rinc); end
        @(posedge clk);
        #1;
        advance(FL + 10, te, be, re, ce);
        checks += 3;
        if (te != 0) begin errors++; $display("FAIL reset_frame_tx got %0d bad cycles want 0", te); end
        if (re != 0) begin errors++; $display("FAIL reset_frame_rinc got %0d bad cycles want 0", re); end
        if (sent_cnt !== 8'd1) begin errors++; $display("FAIL reset_frame_sent got %0d want 1", sent_cnt); end
    endtask

    task automatic test_single();
        int n_rinc, first_rinc, first_low, n_busy, bad;
        logic [10:0] seq;
`ifdef FIFO_UART_PARITY_EN
        seq = 11'b10101001010;
`else
        seq = 11'b01101001010;
`endif
        n_rinc = 0; first_rinc = -1; first_low = -1; n_busy = 0; bad = 0;
        push(8'hA5);
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (rd.rinc === 1'b1) begin
                n_rinc++;
                if (first_rinc < 0) first_rinc = i;
            end
            if (tx === 1'b0 && first_low < 0) first_low = i;
            if (busy === 1'b1) n_busy++;
            if (first_low >= 0 && i - first_low < FL && (i - first_low) % CPB == CPB / 2)
                if (tx !== seq[(i - first_low) / CPB]) bad++;
            @(posedge clk);
            #1;
        end
        checks += 5;
        if (n_rinc != 1) begin errors++; $display("FAIL single_rinc_pulses got %0d want 1", n_rinc); end
        if (first_low - first_rinc != 2) begin errors++; $display("FAIL single_latency got %0d want 2", first_low - first_rinc); end
        if (n_busy != BUSY_LEN) begin errors++; $display("FAIL single_busy_len got %0d want %0d", n_busy, BUSY_LEN); end
        if (bad != 0) begin errors++; $display("FAIL single_tx_bits got %0d bad bits want 0", bad); end
        if (sent_cnt !== 8'd2) begin errors++; $display("FAIL single_sent got %0d want 2", sent_cnt); end
    endtask

    task automatic test_back_to_back();
        int te, be, re, ce, b0;
        logic [7:0] w[3];
        w[0] = 8'h01; w[1] = 8'h80; w[2] = 8'hFF;
        b0 = pop_cyc.size();
        for (int i = 0; i < 3; i++) push(w[i]);
        advance(3 * (FL + 2) + 10, te, be, re, ce);
        checks += 5;
        if (pop_cyc.size() - b0 != 3) begin errors++; $display("FAIL b2b_pops got %0d want 3", pop_cyc.size() - b0); end
        if (te != 0) begin errors++; $display("FAIL b2b_tx got %0d bad cycles want 0", te); end
        if (be != 0) begin errors++; $display("FAIL b2b_busy got %0d bad cycles want 0", be); end
        if (ce != 0) begin errors++; $display("FAIL b2b_sent got %0d bad cycles want 0", ce); end
        if (sent_cnt !== 8'd5) begin errors++; $display("FAIL b2b_sent_final got %0d want 5", sent_cnt); end
        for (int i = 0; i < 3 && b0 + i < pop_cyc.size(); i++) begin
            checks++;
            if (pop_word[b0 + i] !== w[i]) begin errors++; $display("FAIL b2b_word%0d got %h want %h", i, pop_word[b0 + i], w[i]); end
            if (i > 0) begin
                checks++;
                if (pop_cyc[b0 + i] - pop_cyc[b0 + i - 1] != FL + 2) begin
                    errors++;
                    $display("FAIL b2b_spacing%0d got %0d want %0d", i, pop_cyc[b0 + i] - pop_cyc[b0 + i - 1], FL + 2);
                end
            end
        end
    endtask

    task automatic test_gating();
        int te, be, re, ce, b0;
        en = 1'b0;
        b0 = pop_cyc.size();
        push(8'($urandom));
        advance(100, te, be, re, ce);
        checks += 2;
        if (pop_cyc.size() != b0) begin errors++; $display("FAIL gate_no_pop got %0d pops want 0", pop_cyc.size() - b0); end
        if (te != 0) begin errors++; $display("FAIL gate_tx_idle got %0d bad cycles want 0", te); end
        en = 1'b1;
        advance(20, te, be, re, ce);
        en = 1'b0;
        push(8'($urandom));
        advance(FL + 20, te, be, re, ce);
        checks += 4;
        if (pop_cyc.size() - b0 != 1) begin errors++; $display("FAIL gate_drop_pops got %0d want 1", pop_cyc.size() - b0); end
        if (te != 0) begin errors++; $display("FAIL gate_drop_tx got %0d bad cycles want 0", te); end
        if (re != 0) begin errors++; $display("FAIL gate_drop_rinc got %0d bad cycles want 0", re); end
        if (sent_cnt !== 8'd6) begin errors++; $display("FAIL gate_drop_sent got %0d want 6", sent_cnt); end
    endtask

    task automatic test_frame_len();
        int te, be, re, ce, n_busy, par;
        en = 1'b1;
        advance(FL + 10, te, be, re, ce);
        push(8'h07);
        n_busy = 0; par = -1;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (busy === 1'b1) n_busy++;
            if (i == 2 + (DSIZE + 1) * CPB + CPB / 2) par = int'(tx);
            @(posedge clk);
            #1;
        end
        checks += 2;
        if (n_busy != BUSY_LEN) begin errors++; $display("FAIL frame_len_07 got %0d want %0d", n_busy, BUSY_LEN); end
`ifdef FIFO_UART_PARITY_EN
        if (par != 1) begin errors++; $display("FAIL parity_bit_07 got %0d want 1", par); end
`else
        if (par != 1) begin errors++; $display("FAIL stop_bit_07 got %0d want 1", par); end
`endif
    endtask

    task automatic test_random();
        int te, be, re, ce, ste, sbe, sre, sce, b0, bound;
        logic [7:0] words[$];
        logic [7:0] w;
        ste = 0; sbe = 0; sre = 0; sce = 0;
        b0 = pop_cyc.size();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0 && words.size() < 30) begin
                w = 8'($urandom);
                words.push_back(w);
                push(w);
            end
            en = ($urandom_range(0, 9) != 0);
            advance(1, te, be, re, ce);
            ste += te; sbe += be; sre += re; sce += ce;
        end
        en = 1'b1;
        bound = 0;
        while ((fifo_q.size() != 0 || busy !== 1'b0) && bound < 40 * (FL + 2)) begin
            advance(1, te, be, re, ce);
            ste += te; sbe += be; sre += re; sce += ce;
            bound++;
        end
        checks += 6;
        if (bound >= 40 * (FL + 2)) begin errors++; $display("FAIL rand_drain_timeout got %0d cycles want <%0d", bound, 40 * (FL + 2)); end
        if (ste != 0) begin errors++; $display("FAIL rand_tx got %0d bad cycles want 0", ste); end
        if (sbe != 0) begin errors++; $display("FAIL rand_busy got %0d bad cycles want 0", sbe); end
        if (sre != 0) begin errors++; $display("FAIL rand_rinc got %0d bad cycles want 0", sre); end
        if (sce != 0) begin errors++; $display("FAIL rand_sent got %0d bad cycles want 0", sce); end
        if (pop_cyc.size() - b0 != words.size()) begin errors++; $display("FAIL rand_pops got %0d want %0d", pop_cyc.size() - b0, words.size()); end
        for (int i = 0; i < words.size() && b0 + i < pop_word.size(); i++) begin
            checks++;
            if (pop_word[b0 + i] !== words[i]) begin errors++; $display("FAIL rand_word%0d got %h want %h", i, pop_word[b0 + i], words[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int te, be, re, ce;
        en = 1'b1;
        push(8'($urandom));
        advance(2 + 4 * CPB + 1, te, be, re, ce);
        r_rst = 1'b1;
        @(posedge clk);
        #1;
        r_rst = 1'b0;
        log_base = pop_cyc.size();
        @(negedge clk);
        checks += 3;
        if (tx !== 1'b1) begin errors++; $display("FAIL midrst_tx got %b want 1", tx); end
        if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
        if (sent_cnt !== 8'd0) begin errors++; $display("FAIL midrst_sent got %0d want 0", sent_cnt); end
        @(posedge clk);
        #1;
        advance(FL + 10, te, be, re, ce);
        checks += 2;
        if (pop_cyc.size() != log_base) begin errors++; $display("FAIL midrst_no_retx got %0d pops want 0", pop_cyc.size() - log_base); end
        if (te != 0) begin errors++; $display("FAIL midrst_tx_idle got %0d bad cycles want 0", te); end
    endtask

    task automatic test_wrap();
        int te, be, re, ce;
        for (int i = 0; i < 257; i++) push(8'($urandom));
        advance(257 * (FL + 2) + 10, te, be, re, ce);
        checks += 4;
        if (te != 0) begin errors++; $display("FAIL wrap_tx got %0d bad cycles want 0", te); end
        if (re != 0) begin errors++; $display("FAIL wrap_rinc got %0d bad cycles want 0", re); end
        if (ce != 0) begin errors++; $display("FAIL wrap_sent_track got %0d bad cycles want 0", ce); end
        if (sent_cnt !== 8'd1) begin errors++; $display("FAIL wrap_sent got %0d want 1", sent_cnt); end
    endtask

    initial begin
        r_rst = 1'b1;
        en = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_gating();
        test_frame_len();
        test_random();
        test_reset_mid();
        test_wrap();
        checks++;
        if (pop_empty_err != 0) begin errors++; $display("FAIL pop_while_empty got %0d want 0", pop_empty_err); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
